temp_display_scan: RTL and testbench
====================================

// Module: temp_display_scan
// PURPOSE
//  Parametrised serial-temperature receiver plus multiplexed 7-segment driver.
//  Receives framed binary readings from the sensor interface and converts them to BCD with an iterative double-dabble.
//  Drives NUM_DIGITS time-multiplexed common-anode digits with leading-zero blanking and overflow indication.
//  Sits between the MAX6675 front end and the board display pins.
// PARAMETERS
//  DATA_W       12     payload bits per frame (temperature, unsigned)
//  NUM_DIGITS   4      displayed decimal digits (2..6)
//  REFRESH_DIV  50000  clk cycles each digit stays selected (>=2)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active-high
//  serial_en    in   1           bit strobe; serial_data is sampled only when high
//  serial_data  in   1           serial line, idles high
//  seg          out  7           segments {g,f,e,d,c,b,a}, active-low
//  digit_sel    out  NUM_DIGITS  one-hot digit enable, active-low, bit0 = units
//  temp_value   out  DATA_W      last good received value
//  sample_valid out  1           1-cycle pulse when temp_value updates
//  frame_err    out  1           1-cycle pulse on bad stop bit
//  overflow     out  1           high while temp_value > 10^NUM_DIGITS-1
// BEHAVIOUR
//  Reset (sync, rst=1 at a clk edge):
//  - seg=7'h7F; digit_sel=all 1s; temp_value=0; all pulses/flags=0.
//  - BCD register=0; scan index=0; refresh counter=0.
//  - Any frame or conversion in flight is abandoned.
//  Receiver FSM, advancing only on cycles with serial_en=1:
//  - IDLE: serial_data=0 -> RECV, bit_cnt=0.
//  - RECV: shift serial_data in MSB-first; after DATA_W bits -> STOP.
//  - STOP, serial_data=1: temp_value<=shift reg and sample_valid pulses.
//    These happen on the same edge; return to IDLE.
//  - STOP, serial_data=0: frame_err pulses; temp_value is unchanged; return to IDLE.
//  - serial_en=0 cycles stall the FSM; no timeout.
//  Converter FSM:
//  - CIDLE -> CONV when a new value is pending.
//  - CONV runs exactly DATA_W shift cycles of double-dabble.
//  - CONV -> CDONE: the BCD display register is loaded atomically, and overflow updates.
//  - CDONE -> CIDLE.
//  - Latency: sample_valid to display register update = DATA_W+2 clks.
//  - A frame completing during CONV sets pending; the converter reruns with the newest value.
//  - Intermediate values are never shown.
//  Scan:
//  - The refresh counter counts 0..REFRESH_DIV-1.
//  - On wrap, the scan index increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
//  - digit_sel and seg are registered; they change on the same edge as the index.
//  - seg decodes BCD 0-9 to the standard patterns.
//  - Leading zeros above the most significant nonzero digit are blank (7'h7F).
//    Digit 0 always shows a value, so 0 displays as "0".
//  - When overflow=1, every digit shows a dash (7'h3F, only g lit).
//  - BCD nibble >9 (unreachable): show blank.
// TESTING
//  1 rst, frame start=0, 12'd253 MSB-first, stop=1 -> temp_value=253, one sample_valid pulse.
//    DATA_W+2 clks later: units=3 (7'h30), tens=5 (7'h12), hundreds=2 (7'h24), digit3 blank.
//  2 Frame 12'd100 with stop=0 -> one frame_err pulse; temp_value and display are unchanged.
//  3 NUM_DIGITS=3, frame 12'd1000 -> overflow=1, all digits 7'h3F.
//    Next frame 12'd7 -> overflow=0; display "  7".
//  4 REFRESH_DIV=4 -> digit_sel sequence 1110,1101,1011,0111,1110, each held 4 clks.
//  5 Toggle serial_en 1-of-3 cycles during frame 12'd42 -> same result as continuous.
//    Assert rst mid-frame -> all reset values; the next full frame decodes correctly.
//  6 Second frame lands 3 clks into CONV -> display shows only the second value.

Source files
------------

// File: rtl/temp_display_scan.sv
// -----------------------------------------------------------------------------
// temp_display_scan
//
// Purpose:
//   Receives framed serial temperature readings (start bit 0, DATA_W payload
//   bits MSB-first, stop bit 1), converts each good reading to BCD with an
//   iterative double-dabble and drives NUM_DIGITS time-multiplexed
//   common-anode 7-segment digits. Leading zeros are blanked. When the value
//   does not fit in NUM_DIGITS decimal digits, every digit shows a dash.
//
// Parameters:
//   DATA_W       payload bits per frame (unsigned temperature)
//   NUM_DIGITS   number of displayed decimal digits (2..6)
//   REFRESH_DIV  clk cycles each digit stays selected (>= 2)
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   serial_en    bit strobe; serial_data is sampled only when high
//   serial_data  serial line, idles high
//   seg          segments {g,f,e,d,c,b,a}, active-low
//   digit_sel    one-hot digit enable, active-low, bit0 = units
//   temp_value   last good received value
//   sample_valid 1-cycle pulse when temp_value updates
//   frame_err    1-cycle pulse on a bad stop bit
//   overflow     high while the displayed value exceeds 10^NUM_DIGITS-1
// -----------------------------------------------------------------------------
module temp_display_scan #(
  parameter int DATA_W      = 12,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_en,
  input  logic                  serial_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic [DATA_W-1:0]     temp_value,
  output logic                  sample_valid,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int REF_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam int unsigned      MAX_DISP = 10 ** NUM_DIGITS - 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {C_IDLE, C_CONV, C_DONE} conv_state_t;

  // Standard active-low patterns; anything outside 0-9 is left blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  rx_state_t         rx_state, rx_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              rx_good;

  assign rx_good = serial_en && (rx_state == RX_STOP) && serial_data;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // The receiver only moves on strobed cycles; otherwise it simply waits.
  always_comb begin
    rx_next = rx_state;
    if (serial_en) begin
      case (rx_state)
        RX_IDLE: if (!serial_data) rx_next = RX_RECV;
        RX_RECV: if (bit_cnt == LAST_BIT) rx_next = RX_STOP;
        RX_STOP: rx_next = RX_IDLE;
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= '0;
      shift_reg    <= '0;
      temp_value   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (serial_en) begin
        case (rx_state)
          RX_IDLE: if (!serial_data) bit_cnt <= '0;
          RX_RECV: begin
            shift_reg <= {shift_reg[DATA_W-2:0], serial_data};
            bit_cnt   <= bit_cnt + CNT_W'(1);
          end
          RX_STOP: begin
            if (serial_data) begin
              temp_value   <= shift_reg;
              sample_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Double-dabble converter
  // ---------------------------------------------------------------------------
  conv_state_t       conv_state, conv_next;
  logic              pending;
  logic [CNT_W-1:0]  conv_cnt;
  logic [DATA_W-1:0] bin_work;
  logic [DATA_W-1:0] conv_src;
  logic [BCD_W-1:0]  bcd_work;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_disp;

  always_ff @(posedge clk) begin
    if (rst) conv_state <= C_IDLE;
    else     conv_state <= conv_next;
  end

  always_comb begin
    conv_next = conv_state;
    case (conv_state)
      C_IDLE:  if (pending) conv_next = C_CONV;
      C_CONV:  if (conv_cnt == LAST_BIT) conv_next = C_DONE;
      C_DONE:  conv_next = C_IDLE;
      default: conv_next = C_IDLE;
    endcase
  end

  // Add-3 step applied to every digit of 5 or more before each shift. Carries
  // out of the top digit are dropped; that case is shown as overflow anyway.
  always_comb begin
    bcd_adj = bcd_work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_work[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
    end
  end

  // The conversion works in bcd_work and only copies into bcd_disp in C_DONE,
  // so the scan never sees a half-converted number. A reading that lands
  // while busy leaves pending set and the converter reruns on temp_value,
  // which by then holds the newest reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      conv_cnt <= '0;
      bin_work <= '0;
      conv_src <= '0;
      bcd_work <= '0;
      bcd_disp <= '0;
      overflow <= 1'b0;
    end else begin
      case (conv_state)
        C_IDLE: begin
          if (pending) begin
            pending  <= 1'b0;
            bin_work <= temp_value;
            conv_src <= temp_value;
            bcd_work <= '0;
            conv_cnt <= '0;
          end
        end
        C_CONV: begin
          bcd_work <= {bcd_adj[BCD_W-2:0], bin_work[DATA_W-1]};
          bin_work <= {bin_work[DATA_W-2:0], 1'b0};
          conv_cnt <= conv_cnt + CNT_W'(1);
        end
        C_DONE: begin
          bcd_disp <= bcd_work;
          overflow <= (32'(conv_src) > MAX_DISP);
        end
        default: ;
      endcase
      if (rx_good) pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [REF_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] scan_idx, idx_next;
  logic [3:0]       digit_val;
  logic             upper_nz;
  logic [6:0]       seg_next;

  assign idx_next = (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);

  // seg is computed for the digit about to be selected, so the pattern and
  // the digit enable switch together. A digit is blank when it and every
  // digit above it are zero, except the units digit.
  always_comb begin
    digit_val = 4'd0;
    upper_nz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx_next) digit_val = bcd_disp[4*i +: 4];
      if ((IDX_W'(i) >= idx_next) && (bcd_disp[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    if (overflow)                           seg_next = SEG_DASH;
    else if ((idx_next != '0) && !upper_nz) seg_next = SEG_BLANK;
    else                                    seg_next = seg_decode(digit_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      seg         <= SEG_BLANK;
      digit_sel   <= '1;
    end else if (refresh_cnt == REF_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= idx_next;
      digit_sel   <= ~(NUM_DIGITS'(1) << idx_next);
      seg         <= seg_next;
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

endmodule

// File: tb/tb_temp_display_scan.sv
// -----------------------------------------------------------------------------
// tb_temp_display_scan
//
// Drives two instances from the same serial stream: a 4-digit display and a
// 3-digit display (which overflows above 999). A reference model built from
// decimal arithmetic and a schedule of conversion completion times predicts
// every output on every cycle.
// -----------------------------------------------------------------------------
module tb_temp_display_scan;

  localparam int DATA_W = 12;
  localparam int ND_A   = 4;
  localparam int RD_A   = 4;
  localparam int ND_B   = 3;
  localparam int RD_B   = 3;
  localparam int SETTLE = DATA_W + 2 + 5 * RD_A + 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serial_en = 1'b0;
  logic        serial_data = 1'b1;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  digit_sel_a;
  logic [2:0]  digit_sel_b;
  logic [11:0] temp_a, temp_b;
  logic        sv_a, sv_b, fe_a, fe_b, ovf_a, ovf_b;

  always #5 clk = ~clk;

  temp_display_scan #(.DATA_W(DATA_W), .NUM_DIGITS(ND_A), .REFRESH_DIV(RD_A)) dut_a (
    .clk(clk), .rst(rst), .serial_en(serial_en), .serial_data(serial_data),
    .seg(seg_a), .digit_sel(digit_sel_a), .temp_value(temp_a),
    .sample_valid(sv_a), .frame_err(fe_a), .overflow(ovf_a)
  );

  temp_display_scan #(.DATA_W(DATA_W), .NUM_DIGITS(ND_B), .REFRESH_DIV(RD_B)) dut_b (
    .clk(clk), .rst(rst), .serial_en(serial_en), .serial_data(serial_data),
    .seg(seg_b), .digit_sel(digit_sel_b), .temp_value(temp_b),
    .sample_valid(sv_b), .frame_err(fe_b), .overflow(ovf_b)
  );

  int checks = 0;
  int failures = 0;

  // Edge counter: after posedge number n, cyc == n.
  int   cyc = 0;
  logic rstSampled = 1'b0;
  bit   armed = 1'b0;
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rstSampled <= rst;
  end

  // Model state
  typedef struct {
    int start;
    int disp;
    int val;
  } conv_t;
  conv_t convQ[$];
  int dispVal = 0;
  int schedLastDisp = -100;
  int expTemp = 0;
  int lastGoodEdge = -1;
  int lastBadEdge = -1;
  int resetEdge = 0;
  logic [6:0] expSeg[2] = '{7'h7F, 7'h7F};
  int expIdx[2] = '{-1, -1};
  logic [6:0] segTbl[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [6:0] segFor(input int v, input int nd, input int pos);
    if (v > pow10(nd) - 1) return 7'h3F;
    if (pos > 0 && v < pow10(pos)) return 7'h7F;
    return segTbl[(v / pow10(pos)) % 10];
  endfunction

  // A good reading at edge t is displayed 13 edges after the converter picks
  // it up. The converter can pick it up at t+1 at the earliest, and never
  // before the edge after the previous display load. A reading that arrives
  // before an already-scheduled pickup simply replaces the value picked up.
  function automatic void scheduleSample(input int t, input int v);
    conv_t e;
    int s;
    if (convQ.size() > 0 && convQ[convQ.size()-1].start > t) begin
      e = convQ[convQ.size()-1];
      e.val = v;
      convQ[convQ.size()-1] = e;
    end else begin
      s = (t + 1 > schedLastDisp + 1) ? t + 1 : schedLastDisp + 1;
      e.start = s;
      e.disp  = s + DATA_W + 1;
      e.val   = v;
      convQ.push_back(e);
      schedLastDisp = e.disp;
    end
  endfunction

  function automatic void updateScan(input int d, input int n, input int nd, input int rd);
    int k;
    if (n > resetEdge && ((n - resetEdge) % rd) == 0) begin
      k = (n - resetEdge) / rd;
      expIdx[d] = k % nd;
      expSeg[d] = segFor(dispVal, nd, k % nd);
    end
  endfunction

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin : monitor
    int n;
    logic [3:0] selA;
    logic [2:0] selB;
    n = cyc;
    if (rstSampled) armed = 1'b1;
    if (armed) begin
      if (rstSampled) begin
        resetEdge = n;
        convQ.delete();
        dispVal = 0;
        schedLastDisp = -100;
        expTemp = 0;
        expSeg = '{7'h7F, 7'h7F};
        expIdx = '{-1, -1};
      end else begin
        while (convQ.size() > 0 && convQ[0].disp < n) begin
          dispVal = convQ[0].val;
          convQ.pop_front();
        end
        updateScan(0, n, ND_A, RD_A);
        updateScan(1, n, ND_B, RD_B);
        while (convQ.size() > 0 && convQ[0].disp == n) begin
          dispVal = convQ[0].val;
          convQ.pop_front();
        end
      end
      selA = (expIdx[0] < 0) ? 4'hF : ~(4'b0001 << expIdx[0]);
      selB = (expIdx[1] < 0) ? 3'h7 : ~(3'b001 << expIdx[1]);
      checkOutput("digit_sel_a", 32'(digit_sel_a), 32'(selA));
      checkOutput("digit_sel_b", 32'(digit_sel_b), 32'(selB));
      checkOutput("seg_a", 32'(seg_a), 32'(expSeg[0]));
      checkOutput("seg_b", 32'(seg_b), 32'(expSeg[1]));
      checkOutput("temp_a", 32'(temp_a), expTemp);
      checkOutput("temp_b", 32'(temp_b), expTemp);
      checkOutput("sample_valid_a", 32'(sv_a), 32'(n == lastGoodEdge));
      checkOutput("sample_valid_b", 32'(sv_b), 32'(n == lastGoodEdge));
      checkOutput("frame_err_a", 32'(fe_a), 32'(n == lastBadEdge));
      checkOutput("frame_err_b", 32'(fe_b), 32'(n == lastBadEdge));
      checkOutput("overflow_a", 32'(ovf_a), 32'(dispVal > pow10(ND_A) - 1));
      checkOutput("overflow_b", 32'(ovf_b), 32'(dispVal > pow10(ND_B) - 1));
    end
  end

  function automatic int gapsFor(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 2;
    return $urandom_range(0, 3);
  endfunction

  // One bit: optional unstrobed cycles carrying junk, then one strobed cycle.
  task automatic sendBit(input logic b, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      serial_en   = 1'b0;
      serial_data = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    serial_en   = 1'b1;
    serial_data = b;
    @(posedge clk);
    #1;
    serial_en   = 1'b0;
    serial_data = 1'b1;
  endtask

  task automatic applyStimulus(input int value, input logic stopBit, input int gapMode);
    logic [11:0] v;
    v = 12'(value);
    $display("[TB] frame value=%0d stop=%0b gap_mode=%0d", v, stopBit, gapMode);
    sendBit(1'b0, gapsFor(gapMode));
    for (int i = DATA_W - 1; i >= 0; i--) sendBit(v[i], gapsFor(gapMode));
    sendBit(stopBit, gapsFor(gapMode));
    if (stopBit) begin
      expTemp = int'(v);
      lastGoodEdge = cyc;
      scheduleSample(cyc, int'(v));
    end else begin
      lastBadEdge = cyc;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      serial_en   = 1'($urandom_range(0, 1));
      serial_data = 1'b1;
      @(posedge clk);
      #1;
    end
    serial_en = 1'b0;
  endtask

  task automatic applyReset(input int n);
    serial_en   = 1'b0;
    serial_data = 1'b1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int v, stopSel, gap, gapIdle;
    applyReset(3);
    idleCycles(SETTLE);

    // Basic reading and decoding, then a bad stop bit.
    applyStimulus(253, 1'b1, 0);
    idleCycles(SETTLE);
    applyStimulus(100, 1'b0, 0);
    idleCycles(SETTLE);

    // Overflow boundary on the 3-digit instance and leading-zero cases.
    applyStimulus(1000, 1'b1, 0);
    idleCycles(SETTLE);
    applyStimulus(7, 1'b1, 0);
    idleCycles(SETTLE);
    applyStimulus(999, 1'b1, 0);
    idleCycles(SETTLE);
    applyStimulus(0, 1'b1, 0);
    idleCycles(SETTLE);
    applyStimulus(4095, 1'b1, 0);
    idleCycles(SETTLE);

    // Strobe only one cycle in three.
    applyStimulus(42, 1'b1, 1);
    idleCycles(SETTLE);

    // Reset in the middle of a frame, then a clean frame.
    sendBit(1'b0, 0);
    for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(0, 1)), 0);
    applyReset(2);
    idleCycles(10);
    applyStimulus($urandom_range(1, 4095), 1'b1, 0);
    idleCycles(SETTLE);

    // Back-to-back frames: the second lands while the first is converting.
    applyStimulus(321, 1'b1, 0);
    applyStimulus(58, 1'b1, 0);
    idleCycles(SETTLE + DATA_W);

    // Randomized frames, stop bits, strobing and spacing.
    for (int r = 0; r < 25; r++) begin
      v       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4095);
      stopSel = ($urandom_range(0, 5) != 0) ? 1 : 0;
      gap     = $urandom_range(0, 2);
      gapIdle = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 40);
      applyStimulus(v, 1'(stopSel), gap);
      idleCycles(gapIdle);
    end
    idleCycles(SETTLE * 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
